conv_bias_relu_pool: RTL and testbench

Post-processing stage directly downstream of the 3x3 convolution adder tree. It consumes the 20-bit signed window sum plus a valid strobe. It adds the channel bias, applies ReLU, shifts and saturates the result to 16 bits, then performs 2x2 stride-2 max pooling over the convolution output map. The pooled 16-bit stream feeds the next layer's line buffer.

---
 rtl/conv_bias_relu_pool.sv | 136 +++++++++++++
 tb/tb_conv_bias_relu_pool.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_bias_relu_pool.sv
// Bias add, ReLU, shift/saturate to 16 bits, then 2x2 stride-2 max pooling over the conv map.
// Three register stages from din to dout: biased sum, clamped pixel, pooled output.
module conv_bias_relu_pool #(
    parameter int unsigned IMG_W = 26,
    parameter int unsigned IMG_H = 26,
    parameter int unsigned SHIFT = 4
) (
    input  logic        sclk,
    input  logic        s_rst_n,
    input  logic [19:0] din,
    input  logic        din_valid,
    input  logic        din_sof,
    input  logic [15:0] bias,
    output logic [15:0] dout,
    output logic        dout_valid,
    output logic        dout_last
);

    localparam int unsigned PW = IMG_W / 2;
    localparam int unsigned PH = IMG_H / 2;
    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);
    localparam int unsigned AW = (PW > 1) ? $clog2(PW) : 1;

    localparam logic [CW-1:0] COL_MAX  = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX  = RW'(IMG_H - 1);
    localparam logic [CW:0]   COL_LIM  = (CW + 1)'(2 * PW);
    localparam logic [RW:0]   ROW_LIM  = (RW + 1)'(2 * PH);
    localparam logic [CW-1:0] COL_LAST = CW'(2 * PW - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(2 * PH - 1);

    function automatic logic [15:0] smax(input logic [15:0] a, input logic [15:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    logic signed [20:0] sum_q;
    logic               s1_valid, s1_sof;
    logic signed [20:0] shifted;
    logic [15:0]        q_d, q_q;
    logic               q_valid, q_sof;

    logic [CW-1:0]      col_q, eff_col;
    logic [RW-1:0]      row_q, eff_row;
    logic [15:0]        hreg_q;
    logic [15:0]        rowbuf [PW];
    logic [AW-1:0]      buf_idx;
    logic [15:0]        h_max, rd_val;
    logic               in_pool, fire, is_last;

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            sum_q    <= '0;
            s1_valid <= 1'b0;
            s1_sof   <= 1'b0;
        end else begin
            s1_valid <= din_valid;
            s1_sof   <= din_valid & din_sof;
            if (din_valid) begin
                sum_q <= {din[19], din} + {{5{bias[15]}}, bias};
            end
        end
    end

    always_comb begin
        shifted = sum_q >>> SHIFT;
        if (sum_q < 0) begin
            q_d = '0;
        end else if (shifted > 21'sd32767) begin
            q_d = 16'h7fff;
        end else begin
            q_d = shifted[15:0];
        end
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            q_q     <= '0;
            q_valid <= 1'b0;
            q_sof   <= 1'b0;
        end else begin
            q_valid <= s1_valid;
            q_sof   <= s1_sof;
            if (s1_valid) begin
                q_q <= q_d;
            end
        end
    end

    // A start-of-frame pixel is taken as position (0,0) regardless of the counters.
    always_comb begin
        eff_col = q_sof ? '0 : col_q;
        eff_row = q_sof ? '0 : row_q;
        in_pool = ({1'b0, eff_col} < COL_LIM) && ({1'b0, eff_row} < ROW_LIM);
        buf_idx = AW'(eff_col >> 1);
        h_max   = smax(hreg_q, q_q);
        rd_val  = rowbuf[buf_idx];
        fire    = q_valid && in_pool && eff_col[0] && eff_row[0];
        is_last = (eff_col == COL_LAST) && (eff_row == ROW_LAST);
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            col_q      <= '0;
            row_q      <= '0;
            hreg_q     <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
        end else begin
            dout_valid <= fire;
            dout_last  <= fire && is_last;
            if (fire) begin
                dout <= smax(h_max, rd_val);
            end
            if (q_valid) begin
                if (eff_col == COL_MAX) begin
                    col_q <= '0;
                    row_q <= (eff_row == ROW_MAX) ? '0 : eff_row + 1'b1;
                end else begin
                    col_q <= eff_col + 1'b1;
                    row_q <= eff_row;
                end
                if (in_pool && !eff_col[0]) begin
                    hreg_q <= q_q;
                end
            end
        end
    end

    always_ff @(posedge sclk) begin
        if (q_valid && in_pool && eff_col[0] && !eff_row[0]) begin
            rowbuf[buf_idx] <= h_max;
        end
    end

endmodule

// File: tb/tb_conv_bias_relu_pool.sv
// Drives two instances (4x4 SHIFT=0 and 5x5 SHIFT=4) from one stream and checks each output
// cycle against a frame-array reference of the pooled map.
module tb_conv_bias_relu_pool;

    localparam int W0 = 4, H0 = 4, S0 = 0;
    localparam int W1 = 5, H1 = 5, S1 = 4;

    typedef struct {
        int          due;
        logic [15:0] val;
        logic        last;
    } exp_t;

    logic        sclk = 1'b0;
    logic        s_rst_n = 1'b1;
    logic [19:0] din = '0;
    logic        din_valid = 1'b0;
    logic        din_sof = 1'b0;
    logic [15:0] bias = '0;
    logic [15:0] dout0, dout1;
    logic        dv0, dv1, dl0, dl1;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    exp_t        q0[$];
    exp_t        q1[$];
    logic [15:0] fr [2][25];
    int          idx [2];
    logic [15:0] held [2];

    always #5 sclk = ~sclk;

    conv_bias_relu_pool #(.IMG_W(W0), .IMG_H(H0), .SHIFT(S0)) u_a (
        .sclk(sclk), .s_rst_n(s_rst_n), .din(din), .din_valid(din_valid), .din_sof(din_sof),
        .bias(bias), .dout(dout0), .dout_valid(dv0), .dout_last(dl0)
    );

    conv_bias_relu_pool #(.IMG_W(W1), .IMG_H(H1), .SHIFT(S1)) u_b (
        .sclk(sclk), .s_rst_n(s_rst_n), .din(din), .din_valid(din_valid), .din_sof(din_sof),
        .bias(bias), .dout(dout1), .dout_valid(dv1), .dout_last(dl1)
    );

    function automatic logic [15:0] ref_q(input logic [19:0] d, input logic [15:0] b,
                                          input int sh);
        int s;
        s = int'($signed(d)) + int'($signed(b));
        if (s < 0) return 16'd0;
        s = s >> sh;
        return (s > 32767) ? 16'd32767 : 16'(s);
    endfunction

    function automatic logic [15:0] max4(input logic [15:0] a, input logic [15:0] b,
                                         input logic [15:0] c, input logic [15:0] d);
        int m;
        m = int'(a);
        if (int'(b) > m) m = int'(b);
        if (int'(c) > m) m = int'(c);
        if (int'(d) > m) m = int'(d);
        return 16'(m);
    endfunction

    // Place the pixel in its frame array; a completed 2x2 window inside the even-sized region
    // yields one expected output, due three clocks after the pixel is sampled.
    task automatic model(input int u, input logic [19:0] d, input logic [15:0] b, input logic s);
        int w, h, sh, c, r, pw, ph;
        exp_t e;
        w  = (u == 0) ? W0 : W1;
        h  = (u == 0) ? H0 : H1;
        sh = (u == 0) ? S0 : S1;
        pw = w / 2;
        ph = h / 2;
        if (s) idx[u] = 0;
        fr[u][idx[u]] = ref_q(d, b, sh);
        c = idx[u] % w;
        r = idx[u] / w;
        if ((c % 2 == 1) && (r % 2 == 1) && (c < 2 * pw) && (r < 2 * ph)) begin
            e.due  = cyc + 3;
            e.val  = max4(fr[u][(r-1)*w + c-1], fr[u][(r-1)*w + c],
                          fr[u][r*w + c-1], fr[u][r*w + c]);
            e.last = (r == 2 * ph - 1) && (c == 2 * pw - 1);
            if (u == 0) q0.push_back(e);
            else q1.push_back(e);
        end
        idx[u] = (idx[u] + 1) % (w * h);
    endtask

    task automatic check_unit(input int u, input logic v, input logic [15:0] d, input logic l);
        exp_t e;
        logic ev, el;
        logic [15:0] ed;
        ev = 1'b0;
        el = 1'b0;
        ed = held[u];
        if (u == 0 && q0.size() > 0 && q0[0].due == cyc) begin
            e = q0.pop_front(); ev = 1'b1; ed = e.val; el = e.last;
        end
        if (u == 1 && q1.size() > 0 && q1[0].due == cyc) begin
            e = q1.pop_front(); ev = 1'b1; ed = e.val; el = e.last;
        end
        held[u] = ed;
        n_cmp++;
        assert (v === ev && d === ed && l === el) else begin
            n_err++;
            $error("FAIL u%0d_out cyc=%0d: observed v=%0b dout=%0d last=%0b, expected v=%0b dout=%0d last=%0b",
                   u, cyc, v, d, l, ev, ed, el);
        end
    endtask

    task automatic step(input logic v, input logic s, input logic [19:0] d, input logic [15:0] b);
        din       = d;
        din_valid = v;
        din_sof   = s;
        bias      = b;
        if (v && s_rst_n) begin
            model(0, d, b, s);
            model(1, d, b, s);
        end
        @(posedge sclk);
        cyc++;
        @(negedge sclk);
        check_unit(0, dv0, dout0, dl0);
        check_unit(1, dv1, dout1, dl1);
        din_valid = 1'b0;
        din_sof   = 1'b0;
    endtask

    task automatic pix(input logic s, input logic [19:0] d, input logic [15:0] b, input int gap);
        step(1'b1, s, d, b);
        repeat (gap) step(1'b0, 1'b0, 20'($urandom()), 16'($urandom()));
    endtask

    task automatic do_reset();
        s_rst_n = 1'b0;
        #1;
        n_cmp++;
        assert (dout0 === 16'd0 && dv0 === 1'b0 && dl0 === 1'b0 &&
                dout1 === 16'd0 && dv1 === 1'b0 && dl1 === 1'b0) else begin
            n_err++;
            $error("FAIL reset_outputs: observed a=%0d/%0b/%0b b=%0d/%0b/%0b, expected all 0",
                   dout0, dv0, dl0, dout1, dv1, dl1);
        end
        q0.delete();
        q1.delete();
        idx[0] = 0; idx[1] = 0;
        held[0] = '0; held[1] = '0;
        step(1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b0, '0, '0);
        s_rst_n = 1'b1;
    endtask

    initial begin
        logic [19:0] d;
        logic [15:0] b;
        idx[0] = 0; idx[1] = 0;
        held[0] = '0; held[1] = '0;
        #2;
        do_reset();

        // Raster ramp 0..15, no gaps: instance A pools to 5,7,13,15.
        for (int i = 0; i < 16; i++) pix(i == 0, 20'(i), 16'd0, 0);
        repeat (4) step(1'b0, 1'b0, '0, '0);

        // Negative sum clamps to 0; 100+3 shifted by 4 gives 6 on instance B.
        for (int i = 0; i < 25; i++) begin
            if (i == 0) pix(1'b1, -20'sd100, 16'sd50, 0);
            else if (i == 6) pix(1'b0, 20'sd100, 16'sd3, 0);
            else pix(1'b0, 20'd0, 16'd0, 0);
        end
        repeat (4) step(1'b0, 1'b0, '0, '0);

        // Saturation at both extremes.
        for (int i = 0; i < 16; i++) begin
            if (i == 0) pix(1'b1, 20'h80000, 16'h8000, 0);
            else if (i == 5) pix(1'b0, 20'h7ffff, 16'h7fff, 0);
            else if (i == 10) pix(1'b0, 20'h7ffff, 16'h7fff, 1);
            else pix(1'b0, 20'(i * 37), 16'd0, 0);
        end
        repeat (4) step(1'b0, 1'b0, '0, '0);

        // Random full frames with 0-3 idle cycles between pixels.
        for (int f = 0; f < 3; f++) begin
            b = 16'($signed(16'($urandom_range(0, 4000))) - 16'sd2000);
            for (int i = 0; i < 25; i++) begin
                d = 20'($urandom());
                pix(i == 0, d, b, int'($urandom_range(0, 3)));
            end
        end
        repeat (4) step(1'b0, 1'b0, '0, '0);

        // Six pixels of an abandoned frame, then a fresh frame restarted with sof.
        for (int i = 0; i < 6; i++) pix(i == 0, 20'h3ffff, 16'h7fff, 0);
        for (int i = 0; i < 16; i++) pix(i == 0, 20'($urandom_range(0, 2000)), 16'd5,
                                          int'($urandom_range(0, 2)));
        repeat (4) step(1'b0, 1'b0, '0, '0);

        // Reset while a frame and its pipeline are in flight, then a clean frame.
        for (int i = 0; i < 7; i++) pix(i == 0, 20'h1ffff, 16'd100, 0);
        do_reset();
        for (int i = 0; i < 25; i++) pix(i == 0, 20'($urandom_range(0, 60000)), 16'd7,
                                          int'($urandom_range(0, 3)));

        for (int i = 0; i < 10 && (q0.size() > 0 || q1.size() > 0); i++)
            step(1'b0, 1'b0, '0, '0);
        n_cmp++;
        assert (q0.size() == 0 && q1.size() == 0) else begin
            n_err++;
            $error("FAIL drain: observed %0d/%0d outputs still pending, expected 0/0",
                   q0.size(), q1.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
